// File: rtl/mux_seq_ctrl.sv
// Walks the layer-output mux select across the first count+1 inputs and
// presents each selected word as a registered valid/ready stream.
module mux_seq_ctrl #(
  parameter int DATA_W = 16,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [SEL_W-1:0]  count,
  output logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] mux_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t           state;
  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] cnt;
  logic             capture;
  logic             xfer;

  // A capture may overwrite the output register in the same cycle its beat leaves.
  assign capture = (state == RUN) && (!out_valid || out_ready);
  assign xfer    = out_valid && out_ready;
  assign sel     = idx;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            cnt   <= count;
            idx   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (capture) begin
            out_data  <= mux_data;
            out_valid <= 1'b1;
            out_last  <= (idx == cnt);
            if (idx == cnt) begin
              idx   <= '0;
              state <= DRAIN;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (xfer) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_seq_ctrl.sv
// Scoreboard bench for mux_seq_ctrl: expected beats are queued when a burst
// starts and checked against each transferred beat.
module tb_mux_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  count;
  logic [3:0]  sel;
  logic [15:0] mux_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [15:0] mux_mem [16];
  logic [16:0] sb [$];

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int e0 = 0;
  int ready_mode = 0;
  int ready_phase = 0;

  int  beat_count, first_cyc, last_cyc, done_count, done_cyc, busy_cycles;
  logic sel_nonzero;

  assign mux_data = mux_mem[sel];

  always #5 clk = ~clk;

  mux_seq_ctrl #(.DATA_W(16), .SEL_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .count     (count),
    .sel       (sel),
    .mux_data  (mux_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  task automatic loadMux(input logic [15:0] base, input logic [15:0] step);
    for (int i = 0; i < 16; i++) mux_mem[i] = base + step * 16'(i);
  endtask

  task automatic clearStats();
    beat_count = 0; first_cyc = 0; last_cyc = 0;
    done_count = 0; done_cyc = 0; busy_cycles = 0; sel_nonzero = 1'b0;
  endtask

  // Drives an accepted start and queues every beat the burst must produce.
  task automatic applyStimulus(input logic [3:0] n);
    start = 1'b1;
    count = n;
    e0 = cyc + 1;
    for (int i = 0; i <= int'(n); i++) sb.push_back({(i == int'(n)), mux_mem[i]});
    @(posedge clk); #1;
    start = 1'b0;
    count = 4'($urandom_range(0, 15));
  endtask

  task automatic waitIdle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!busy && !out_valid && sb.size() == 0) break;
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idle_busy", 32'(busy), 0);
    checkOutput("sb_empty", sb.size(), 0);
  endtask

  task automatic waitDone(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (done) break;
    end
    checkOutput("done_seen", 32'(done), 1);
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      ready_phase++;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (ready_phase % 3 == 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: scoreboard pops on every transfer, stall stability, done/busy tallies.
  initial begin : monitor
    logic [16:0] exp_beat;
    logic        stalled;
    logic [15:0] held_data;
    logic        held_last;
    logic [3:0]  held_sel;
    stalled = 1'b0;
    held_data = '0; held_last = 1'b0; held_sel = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
      end else begin
        if (busy) busy_cycles++;
        if (done) begin done_count++; done_cyc = cyc; end
        if (sel != 4'd0) sel_nonzero = 1'b1;
        if (stalled) begin
          checkOutput("stall_data", 32'(out_data), 32'(held_data));
          checkOutput("stall_last", 32'(out_last), 32'(held_last));
          checkOutput("stall_sel", 32'(sel), 32'(held_sel));
        end
        if (out_valid && out_ready) begin
          checkOutput("beat_expected", 32'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            exp_beat = sb.pop_front();
            checkOutput("beat_data", 32'(out_data), 32'(exp_beat[15:0]));
            checkOutput("beat_last", 32'(out_last), 32'(exp_beat[16]));
          end
          if (beat_count == 0) first_cyc = cyc;
          last_cyc = cyc;
          beat_count++;
        end
        stalled   = out_valid && !out_ready;
        held_data = out_data;
        held_last = out_last;
        held_sel  = sel;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; count = '0;
    loadMux(16'h1000, 16'h0001);
    clearStats();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_data", 32'(out_data), 0);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_out_last", 32'(out_last), 0);
    checkOutput("rst_sel", 32'(sel), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] test 1: full 16-beat burst");
    clearStats();
    applyStimulus(4'd15);
    waitIdle(60);
    checkOutput("t1_beats", beat_count, 16);
    checkOutput("t1_first_cyc", first_cyc, e0 + 1);
    checkOutput("t1_last_cyc", last_cyc, e0 + 16);
    checkOutput("t1_done_count", done_count, 1);
    checkOutput("t1_done_cyc", done_cyc, last_cyc + 1);
    checkOutput("t1_busy_cycles", busy_cycles, 17);

    $display("[TB] test 2: single-item burst");
    loadMux(16'h2200, 16'h0003);
    clearStats();
    applyStimulus(4'd0);
    waitIdle(20);
    checkOutput("t2_beats", beat_count, 1);
    checkOutput("t2_sel_nonzero", 32'(sel_nonzero), 0);
    checkOutput("t2_done_count", done_count, 1);

    $display("[TB] test 3: toggling ready");
    loadMux(16'h3A00, 16'h0011);
    clearStats();
    ready_mode = 1;
    applyStimulus(4'd5);
    waitIdle(80);
    ready_mode = 0;
    checkOutput("t3_beats", beat_count, 6);
    checkOutput("t3_done_count", done_count, 1);

    $display("[TB] test 4: start while busy, start in done cycle");
    loadMux(16'h4000, 16'h0007);
    clearStats();
    applyStimulus(4'd3);
    start = 1'b1; count = 4'd9;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(30);
    checkOutput("t4_first_beats", beat_count, 4);
    applyStimulus(4'd9);
    waitIdle(60);
    checkOutput("t4_total_beats", beat_count, 14);
    checkOutput("t4_done_count", done_count, 2);

    $display("[TB] test 5: reset mid-burst");
    loadMux(16'h5000, 16'h0001);
    clearStats();
    applyStimulus(4'd15);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (beat_count >= 3) break;
    end
    #1;
    rst = 1'b1;
    #1;
    checkOutput("t5_beats_before", beat_count, 3);
    checkOutput("t5_out_valid", 32'(out_valid), 0);
    checkOutput("t5_out_data", 32'(out_data), 0);
    checkOutput("t5_out_last", 32'(out_last), 0);
    checkOutput("t5_sel", 32'(sel), 0);
    checkOutput("t5_busy", 32'(busy), 0);
    checkOutput("t5_done", 32'(done), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("t5_no_done", done_count, 0);
    @(posedge clk); #1;
    clearStats();
    applyStimulus(4'd1);
    waitIdle(20);
    checkOutput("t5_new_beats", beat_count, 2);
    checkOutput("t5_new_done", done_count, 1);

    $display("[TB] test 6: long stall after first capture");
    loadMux(16'h6000, 16'h0005);
    clearStats();
    ready_mode = 2;
    applyStimulus(4'd2);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid) break;
    end
    repeat (19) @(posedge clk);
    #1;
    checkOutput("t6_valid_held", 32'(out_valid), 1);
    checkOutput("t6_data_held", 32'(out_data), 32'(mux_mem[0]));
    checkOutput("t6_sel_held", 32'(sel), 1);
    checkOutput("t6_no_beats", beat_count, 0);
    ready_mode = 0;
    waitIdle(30);
    checkOutput("t6_beats", beat_count, 3);
    checkOutput("t6_consecutive", last_cyc - first_cyc, 2);
    checkOutput("t6_done_count", done_count, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/mux_seq_ctrl.md
Name: mux_seq_ctrl

Overview:
Sequencer that walks the select input of the 16:1, 16-bit layer-output mux across the first N inputs. It registers each selected word and presents the words as a valid/ready stream to the next layer or output buffer. It sits between the neuron array outputs, through the mux, and the serial consumer.

Parameters:
DATA_W, 16, width of mux data and stream data
SEL_W, 4, select width; the number of mux inputs is 2^SEL_W = 16

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  begin a burst; sampled only in IDLE
count  input  SEL_W  number of items minus 1 (0 gives 1 item, 15 gives 16); latched on the accepted start
sel  output  SEL_W  select driven to the mux
mux_data  input  DATA_W  combinational mux output for the current sel
out_data  output  DATA_W  registered stream data
out_valid  output  1  out_data holds a valid item
out_ready  input  1  consumer accepts out_data this cycle
out_last  output  1  qualifies the final item of the burst
busy  output  1  high in RUN and DRAIN
done  output  1  one-cycle pulse when a burst completes

Behaviour:
- Reset (async assert, synchronous release): state=IDLE; sel=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0; internal idx=0, cnt=0.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 at an edge: cnt<=count, idx<=0, go to RUN.
  - start=0: stay.
- sel = idx in every state. sel is a direct function of the idx register and never changes while a capture is stalled.
- Capture condition: state==RUN && (!out_valid || out_ready).
- On capture:
  - out_data<=mux_data, out_valid<=1, out_last<=(idx==cnt).
  - If idx==cnt: go to DRAIN, idx<=0.
  - Otherwise: idx<=idx+1.
- Handshake:
  - A beat transfers on any edge with out_valid&&out_ready.
  - In RUN, capture and transfer may coincide; the register is overwritten with the next item.
  - With out_ready held at 1, throughput is one item per clock.
  - A transfer with no capture clears out_valid and out_last.
  - While out_valid=1 and out_ready=0, out_data, out_last and sel are held stable.
- Latency:
  - start is accepted at edge E0; sel=0 during the following cycle.
  - Item 0 appears on out_data with out_valid=1 after edge E1.
  - Item k appears after edge E1+k when out_ready=1 throughout.
- DRAIN:
  - No captures.
  - When the last beat transfers: out_valid<=0, out_last<=0, go to IDLE, done<=1 for exactly one cycle.
- busy = (state!=IDLE). busy falls in the same cycle that done pulses.
- start while busy is ignored and is not queued. start in the cycle done is high is accepted, since state is IDLE.
- count and start changes outside the accepted-start edge have no effect on a burst in progress.
- Every index 0..cnt is emitted exactly once, in ascending order, including index 4. No index is skipped or repeated.
- Wrap-around: with count=15, idx reaches 15 and then returns to 0. There is no overflow into a 17th beat.
- Reset mid-burst aborts immediately. The pending out_valid beat is dropped and done is not pulsed.
- out_ready is a don't-care while out_valid=0.

Test Plan:
1. Reset, then start with count=15, out_ready=1, and mux input i = 16'h1000+i:
   - Beats 16'h1000..16'h100F arrive on 16 consecutive cycles starting 2 edges after start.
   - out_last is high only with 16'h100F.
   - done pulses one cycle after the last beat; busy is high for 17 cycles.
2. count=0:
   - Exactly one beat (input 0) with out_last=1, then done.
   - sel never leaves 0.
3. count=5, out_ready toggling 1,0,0,1,...:
   - Beats 0..5 arrive in order with no loss or duplicates; index 4 is present.
   - out_data and sel are stable during stalls.
4. start pulsed again mid-burst (count=3, second start with count=9):
   - Exactly 4 beats are produced and the second start is ignored.
   - A start issued in the done cycle begins a new 10-beat burst.
5. rst asserted asynchronously after the 3rd beat of a 16-beat burst:
   - All outputs go to 0 immediately with no done pulse.
   - After release, a new start with count=1 yields beats 0 and 1 only.
6. out_ready held at 0 for 20 cycles after the first capture (count=2):
   - out_valid stays 1 with item 0 and sel stays 1.
   - Once ready rises, items 0, 1, 2 transfer on 3 consecutive cycles.
